// File: rtl/blk_scan_ctrl.sv
// Block-grid scan sequencer: turns de_i/vs_i timing into block save strobes and coordinates.
// Optional statistics outputs are enabled with the BLK_SCAN_CTRL_STATS_EN macro.
module blk_scan_ctrl #(
    parameter int unsigned HBLKS = 10,
    parameter int unsigned VBLKS = 10,
    parameter int unsigned BLK_W = 30,
    parameter int unsigned BLK_H = 30
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     de_i,
    input  logic                     vs_i,
    output logic                     h_save_o,
    output logic                     v_save_o,
    output logic                     frame_start_o,
    output logic [$clog2(HBLKS)-1:0] blk_x_o,
    output logic [$clog2(VBLKS)-1:0] blk_y_o,
`ifdef BLK_SCAN_CTRL_STATS_EN
    output logic [15:0]              frame_cnt_o,
    output logic [15:0]              last_w_o,
    output logic [15:0]              last_h_o,
`endif
    output logic                     err_o
);

    localparam int unsigned PX_W = (BLK_W > 1) ? $clog2(BLK_W) : 1;
    localparam int unsigned HB_W = $clog2(HBLKS);
    localparam int unsigned LN_W = (BLK_H > 1) ? $clog2(BLK_H) : 1;
    localparam int unsigned VB_W = $clog2(VBLKS);

    localparam logic [PX_W-1:0] PX_MAX = PX_W'(BLK_W - 1);
    localparam logic [HB_W-1:0] HB_MAX = HB_W'(HBLKS - 1);
    localparam logic [LN_W-1:0] LN_MAX = LN_W'(BLK_H - 1);
    localparam logic [VB_W-1:0] VB_MAX = VB_W'(VBLKS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GAP  = 2'd1;
    localparam logic [1:0] S_LINE = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]      r_state;
    logic            r_vs;
    logic [PX_W-1:0] r_px_cnt;
    logic [HB_W-1:0] r_hblk;
    logic [LN_W-1:0] r_ln_cnt;
    logic [VB_W-1:0] r_vblk;
    // Set once the last block of the line has been saved; later pixels are over-long.
    logic            r_full;

    logic w_vs_rise;
    logic w_in_frame;
    logic w_px_last;
    logic w_hb_last;
    logic w_ln_last;
    logic w_vb_last;
    logic w_eol;

    always_comb begin
        w_vs_rise  = vs_i & ~r_vs;
        w_in_frame = (r_state == S_GAP) || (r_state == S_LINE);
        w_px_last  = (r_px_cnt == PX_MAX);
        w_hb_last  = (r_hblk == HB_MAX);
        w_ln_last  = (r_ln_cnt == LN_MAX);
        w_vb_last  = (r_vblk == VB_MAX);
        w_eol      = ~w_vs_rise & ~de_i & (r_state == S_LINE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= S_IDLE;
            r_vs          <= 1'b0;
            r_px_cnt      <= '0;
            r_hblk        <= '0;
            r_ln_cnt      <= '0;
            r_vblk        <= '0;
            r_full        <= 1'b0;
            h_save_o      <= 1'b0;
            v_save_o      <= 1'b0;
            frame_start_o <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            r_vs          <= vs_i;
            h_save_o      <= 1'b0;
            v_save_o      <= 1'b0;
            frame_start_o <= 1'b0;
            if (w_vs_rise) begin
                r_state       <= S_GAP;
                r_px_cnt      <= '0;
                r_hblk        <= '0;
                r_ln_cnt      <= '0;
                r_vblk        <= '0;
                r_full        <= 1'b0;
                frame_start_o <= 1'b1;
                err_o         <= w_in_frame;
            end else begin
                case (r_state)
                    S_GAP, S_LINE: begin
                        if (de_i) begin
                            r_state <= S_LINE;
                            if (r_full) begin
                                err_o <= 1'b1;
                            end else begin
                                h_save_o <= w_px_last;
                                v_save_o <= w_px_last & w_hb_last & w_ln_last;
                                if (w_px_last) begin
                                    r_px_cnt <= '0;
                                    if (w_hb_last) begin
                                        r_full <= 1'b1;
                                    end else begin
                                        r_hblk <= r_hblk + 1'b1;
                                    end
                                end else begin
                                    r_px_cnt <= r_px_cnt + 1'b1;
                                end
                            end
                        end else if (w_eol) begin
                            r_px_cnt <= '0;
                            r_hblk   <= '0;
                            r_full   <= 1'b0;
                            if (!r_full) begin
                                err_o <= 1'b1;
                            end
                            if (w_ln_last) begin
                                r_ln_cnt <= '0;
                                r_vblk   <= w_vb_last ? '0 : r_vblk + 1'b1;
                            end else begin
                                r_ln_cnt <= r_ln_cnt + 1'b1;
                            end
                            r_state <= (w_ln_last && w_vb_last) ? S_DONE : S_GAP;
                        end
                    end
                    S_DONE: begin
                        if (de_i) begin
                            err_o <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign blk_x_o = r_hblk;
    assign blk_y_o = r_vblk;

`ifdef BLK_SCAN_CTRL_STATS_EN
    logic [15:0] r_frame_cnt;
    logic [15:0] r_last_w;
    logic [15:0] r_last_h;
    logic [15:0] r_line_px;
    logic [15:0] r_frame_ln;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_frame_cnt <= '0;
            r_last_w    <= '0;
            r_last_h    <= '0;
            r_line_px   <= '0;
            r_frame_ln  <= '0;
        end else if (w_vs_rise) begin
            r_last_h   <= r_frame_ln;
            r_frame_ln <= '0;
            r_line_px  <= '0;
        end else if (w_in_frame) begin
            if (de_i) begin
                if (r_state == S_GAP) begin
                    r_line_px <= 16'd1;
                end else if (r_line_px != 16'hFFFF) begin
                    r_line_px <= r_line_px + 16'd1;
                end
            end else if (w_eol) begin
                r_last_w <= r_line_px;
                if (r_frame_ln != 16'hFFFF) begin
                    r_frame_ln <= r_frame_ln + 16'd1;
                end
                if (w_ln_last && w_vb_last) begin
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end
            end
        end
    end

    assign frame_cnt_o = r_frame_cnt;
    assign last_w_o    = r_last_w;
    assign last_h_o    = r_last_h;
`endif

endmodule

// File: tb/tb_blk_scan_ctrl.sv
// Self-checking bench for blk_scan_ctrl on a 2x2 grid of 3x2-pixel blocks, using a
// line-level reference model (pixels per line, lines per frame) driven by directed and random frames.
module tb_blk_scan_ctrl;

    localparam int HB = 2;
    localparam int VB = 2;
    localparam int BW = 3;
    localparam int BH = 2;
    localparam int LINE_PX = HB * BW;
    localparam int FRAME_LN = VB * BH;

    logic clk = 1'b0;
    logic rst_n;
    logic de;
    logic vs;
    logic h_save;
    logic v_save;
    logic frame_start;
    logic [0:0] blk_x;
    logic [0:0] blk_y;
    logic err;
`ifdef BLK_SCAN_CTRL_STATS_EN
    logic [15:0] frame_cnt;
    logic [15:0] last_w;
    logic [15:0] last_h;
`endif

    int total = 0;
    int bad = 0;

    // Reference model state, at line granularity
    bit in_frame;
    bit in_line;
    bit prev_vs;
    int lines;
    int cur_len;
    logic e_h, e_v, e_fs, e_err;
    int e_x, e_y;
    int m_fcnt, m_lastw, m_lasth, m_flines;

    blk_scan_ctrl #(
        .HBLKS(HB),
        .VBLKS(VB),
        .BLK_W(BW),
        .BLK_H(BH)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .de_i         (de),
        .vs_i         (vs),
        .h_save_o     (h_save),
        .v_save_o     (v_save),
        .frame_start_o(frame_start),
        .blk_x_o      (blk_x),
        .blk_y_o      (blk_y),
`ifdef BLK_SCAN_CTRL_STATS_EN
        .frame_cnt_o  (frame_cnt),
        .last_w_o     (last_w),
        .last_h_o     (last_h),
`endif
        .err_o        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("h_save", {31'd0, h_save}, {31'd0, e_h});
        chk("v_save", {31'd0, v_save}, {31'd0, e_v});
        chk("frame_start", {31'd0, frame_start}, {31'd0, e_fs});
        chk("err", {31'd0, err}, {31'd0, e_err});
        chk("blk_x", {31'd0, blk_x}, e_x);
        chk("blk_y", {31'd0, blk_y}, e_y);
`ifdef BLK_SCAN_CTRL_STATS_EN
        chk("frame_cnt", {16'd0, frame_cnt}, m_fcnt);
        chk("last_w", {16'd0, last_w}, m_lastw);
        chk("last_h", {16'd0, last_h}, m_lasth);
`endif
    endtask

    task automatic model_reset();
        in_frame = 0; in_line = 0; prev_vs = 0; lines = 0; cur_len = 0;
        e_h = 0; e_v = 0; e_fs = 0; e_err = 0; e_x = 0; e_y = 0;
        m_fcnt = 0; m_lastw = 0; m_lasth = 0; m_flines = 0;
    endtask

    // Check what the previous cycle produced, apply new inputs, predict the next cycle.
    task automatic step(input logic d, input logic v);
        bit vs_rise;
        @(negedge clk);
        check_outputs();
        de = d;
        vs = v;
        vs_rise = v && !prev_vs;
        prev_vs = v;
        e_h = 0; e_v = 0; e_fs = 0;
        if (vs_rise) begin
            e_fs = 1;
            e_err = in_frame && (lines < FRAME_LN);
            m_lasth = m_flines;
            m_flines = 0;
            in_frame = 1; in_line = 0; lines = 0; cur_len = 0;
        end else if (in_frame && lines < FRAME_LN) begin
            if (d) begin
                in_line = 1;
                cur_len++;
                if (cur_len % BW == 0 && cur_len <= LINE_PX) begin
                    e_h = 1;
                    e_v = (cur_len == LINE_PX) && (lines % BH == BH - 1);
                end
                if (cur_len > LINE_PX) e_err = 1;
            end else if (in_line) begin
                in_line = 0;
                if (cur_len < LINE_PX) e_err = 1;
                m_lastw = cur_len;
                m_flines++;
                lines++;
                if (lines == FRAME_LN) m_fcnt++;
                cur_len = 0;
            end
        end else if (in_frame && d) begin
            e_err = 1;
        end
        if (in_frame && lines < FRAME_LN) begin
            e_x = (cur_len / BW > HB - 1) ? HB - 1 : cur_len / BW;
            e_y = lines / BH;
        end else begin
            e_x = 0;
            e_y = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        de = 0;
        vs = 0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic line(input int len, input int gap);
        for (int k = 0; k < len; k++) step(1'b1, 1'b0);
        for (int k = 0; k < gap; k++) step(1'b0, 1'b0);
    endtask

    task automatic vs_pulse();
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic frame4(input int l0, input int l1, input int l2, input int l3);
        vs_pulse();
        line(l0, 4);
        line(l1, 4);
        line(l2, 4);
        line(l3, 4);
    endtask

    initial begin
        int nl;
        int len;
        rst_n = 0;
        de = 0;
        vs = 0;
        model_reset();
        #1;
        check_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1;

        // Nominal frame, closed by the next vs
        frame4(6, 6, 6, 6);
        vs_pulse();

        // Short first line, then a complete frame
        frame4(5, 6, 6, 6);
        frame4(6, 6, 6, 6);
        vs_pulse();

        // Over-long third line
        frame4(6, 6, 8, 6);

        // Truncated frame: vs rises three pixels into line 3
        vs_pulse();
        line(6, 4);
        line(6, 4);
        repeat (3) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        frame4(6, 6, 6, 6);

        // Reset during line 2; de before the next vs must stay silent
        vs_pulse();
        line(6, 4);
        repeat (3) step(1'b1, 1'b0);
        do_reset();
        line(6, 4);
        line(6, 4);
        frame4(6, 6, 6, 6);

        // Random frames: varied line counts, widths and gaps
        for (int f = 0; f < 8; f++) begin
            nl = $urandom_range(3, 5);
            vs_pulse();
            for (int l = 0; l < nl; l++) begin
                len = ($urandom_range(0, 2) == 0) ? $urandom_range(4, 8) : LINE_PX;
                line(len, $urandom_range(1, 5));
            end
        end
        vs_pulse();

        // Two nominal frames from reset for the statistics outputs
        do_reset();
        frame4(6, 6, 6, 6);
        frame4(6, 6, 6, 6);
        step(1'b0, 1'b0);
`ifdef BLK_SCAN_CTRL_STATS_EN
        chk("frame_cnt_final", {16'd0, frame_cnt}, 2);
        chk("last_w_final", {16'd0, last_w}, 6);
        chk("last_h_final", {16'd0, last_h}, 4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/blk_scan_ctrl.md
Name: blk_scan_ctrl

Overview:
- Sequencer for the block-statistics accumulator.
- Tracks raw video timing (de_i, vs_i) and produces per-block-column save strobes (h_save_o), per-block-row save strobes (v_save_o) and current block coordinates.
- Sits between the video input stage and the block accumulator.
- Flags malformed frames whose geometry does not match the configured block grid.

Parameters:
- HBLKS, 10, blocks per line.
- VBLKS, 10, block rows per frame.
- BLK_W, 30, pixels per block horizontally.
- BLK_H, 30, lines per block vertically.

Ports:
- clk_i  input  1  pixel clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- de_i  input  1  data enable; one active pixel per high cycle.
- vs_i  input  1  vertical sync, active high; its rising edge starts a frame.
- h_save_o  output  1  one-cycle strobe at the end of each block column on every line.
- v_save_o  output  1  one-cycle strobe at the end of each block row.
- frame_start_o  output  1  one-cycle strobe on frame start.
- blk_x_o  output  $clog2(HBLKS)  block column of the pixel currently on de_i.
- blk_y_o  output  $clog2(VBLKS)  block row of the current line.
- err_o  output  1  geometry error flag.

Behaviour:
- Reset values: all outputs 0, state S_IDLE, all counters 0.
- Counters:
  - px_cnt 0..BLK_W-1 and hblk 0..HBLKS-1 advance on each de_i cycle.
  - ln_cnt 0..BLK_H-1 and vblk 0..VBLKS-1 advance on each de_i falling edge.
  - Each wraps to 0 at its max; the next-level counter increments on that wrap.
- States:
  - S_IDLE: ignore de_i.
  - S_GAP: in frame, between lines.
  - S_LINE: de_i high.
  - S_DONE: all VBLKS*BLK_H lines received.
- Transitions:
  - vs_i rising edge (vs_i & ~vs_r), from any state: go to S_GAP, clear all counters, frame_start_o=1 next cycle. This has priority over every other event, including mid-line.
  - S_GAP & de_i: go to S_LINE; the current pixel is counted.
  - S_LINE & ~de_i: end of line, checked as below.
    - If the line count is now VBLKS*BLK_H, go to S_DONE; otherwise go to S_GAP.
    - Then clear px_cnt and hblk.
  - S_DONE & de_i: set err_o and stay in S_DONE. Extra lines produce no strobes.
- Strobes (all registered, 1-cycle latency):
  - h_save_o is high the cycle after a de_i cycle with px_cnt==BLK_W-1, i.e. HBLKS pulses per full line.
  - v_save_o is high together with the final h_save_o of the last line of a block row (ln_cnt==BLK_H-1, hblk==HBLKS-1).
  - blk_x_o and blk_y_o are combinational from hblk and vblk.
- Over-long line: pixels beyond HBLKS*BLK_W produce no strobe; hblk saturates at HBLKS-1; err_o=1.
- Short line: de_i falls before HBLKS*BLK_W pixels; err_o=1; no strobe is generated for the partial block.
- err_o update on vs_i rising edge:
  - err_o <= 1 if the state was S_GAP or S_LINE (truncated frame).
  - err_o <= 0 if the state was S_DONE or S_IDLE.
  - Otherwise err_o is sticky for the frame.
- Reset mid-frame: return immediately to S_IDLE; the next vs_i edge is required before any strobe.
- Width rules: counters sized $clog2(max+1); no wider arithmetic.

Optional Feature:
- Macro: BLK_SCAN_CTRL_STATS_EN.
- When defined, add outputs:
  - frame_cnt_o [15:0]: wrapping count of completed frames; increments on entry to S_DONE.
  - last_w_o [15:0]: pixels of the most recent line; updated at each de_i fall, saturating at 16'hFFFF.
  - last_h_o [15:0]: lines in the previous frame; captured at vs_i rise, saturating.
  - All reset to 0.
- When undefined, these ports and registers do not exist; the remaining behaviour is identical.

Test Plan (HBLKS=2, VBLKS=2, BLK_W=3, BLK_H=2 unless stated):
- Nominal frame: vs pulse, then 4 lines of 6 de cycles with 4-cycle gaps.
  - frame_start_o one cycle after the vs rise.
  - h_save_o one cycle after de cycles 3 and 6 of each line (8 pulses total).
  - v_save_o coincident with the 2nd h_save of lines 2 and 4.
  - err_o=0 after the next vs.
- Short line: line 1 has 5 de cycles.
  - Only 1 h_save_o on that line; err_o=1 after its de fall.
  - err_o=0 on the next vs following a complete frame.
- Long line: line 3 has 8 de cycles.
  - Exactly 2 h_save_o; blk_x_o stays at 1 for cycles 4..8; err_o=1.
- Truncated frame: vs rises during line 3.
  - Counters clear; frame_start_o pulses; err_o=1.
  - Subsequent nominal frame produces 8 h_save_o.
- Reset mid-line: rst_ni low during line 2, then released.
  - All outputs 0; de_i before the next vs yields no strobes.
- BLK_SCAN_CTRL_STATS_EN defined: two nominal frames.
  - frame_cnt_o=2; last_w_o=6; last_h_o=4.
